// File: rtl/mem_responder.sv
// Memory-side responder for the mem_pkt_t valid/ready protocol: services READ/WRITE
// requests from a word array and returns in-order responses through a credit-limited FIFO.
package mem_pkg;
  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_type_e;

  typedef struct packed {
    mem_type_e   mtype;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_pkt_t;
endpackage

module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned RSP_FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [$bits(mem_pkt_t)-1:0] req,
  output logic                        rsp_vld,
  input  logic                        rsp_rdy,
  output logic [$bits(mem_pkt_t)-1:0] rsp
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int unsigned PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  mem_pkt_t        req_pkt;
  mem_pkt_t        rsp_new;
  mem_pkt_t        push_pkt;
  logic            push;
  logic            accept;
  logic            pop;
  logic [CW-1:0]   outstanding;
  logic [AW-1:0]   idx;
  logic [1:0]      off;
  logic [2:0]      nbytes;
  logic [3:0]      lane_en;
  logic [31:0]     wr_word;
  logic [31:0]     rd_shift;
  logic [31:0]     rd_data;
  logic [31:0]     mem [MEM_WORDS];

  mem_pkt_t        fifo [RSP_FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  assign req_pkt = mem_pkt_t'(req);
  assign idx     = req_pkt.addr[AW+1:2];
  assign off     = req_pkt.addr[1:0];
  assign nbytes  = (req_pkt.len == 2'd0) ? 3'd4 : {1'b0, req_pkt.len};

  assign req_rdy = rst_n && (outstanding < CW'(RSP_FIFO_DEPTH));
  assign accept  = req_vld && req_rdy;
  assign rsp_vld = rst_n && (count != '0);
  assign pop     = rsp_vld && rsp_rdy;
  assign rsp     = rsp_vld ? fifo[rd_ptr] : '0;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (32'(p) == RSP_FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Lanes past byte 3 are simply never enabled, so nothing spills into the next word.
  always_comb begin
    lane_en  = '0;
    wr_word  = '0;
    rd_shift = mem[idx] >> {off, 3'b000};
    rd_data  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i >= 32'(off) && i < 32'(off) + 32'(nbytes)) begin
        lane_en[i]       = 1'b1;
        wr_word[8*i +: 8] = req_pkt.data[8*(i - 32'(off)) +: 8];
      end
      if (i < 32'(nbytes)) rd_data[8*i +: 8] = rd_shift[8*i +: 8];
    end
    rsp_new      = req_pkt;
    rsp_new.data = (req_pkt.mtype == MEM_WRITE) ? '0 : rd_data;
  end

  always_ff @(posedge clk) begin
    if (accept && req_pkt.mtype == MEM_WRITE) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push     = accept;
      assign push_pkt = rsp_new;
    end else begin : g_pipe
      logic [LATENCY-2:0] pipe_vld;
      mem_pkt_t           pipe_pkt [LATENCY-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pipe_vld <= '0;
        end else begin
          pipe_vld[0] <= accept;
          for (int unsigned i = 1; i < LATENCY - 1; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
        pipe_pkt[0] <= rsp_new;
        for (int unsigned i = 1; i < LATENCY - 1; i++) pipe_pkt[i] <= pipe_pkt[i-1];
      end

      assign push     = pipe_vld[LATENCY-2];
      assign push_pkt = pipe_pkt[LATENCY-2];
    end
  endgenerate

  // Credits cover pipeline plus FIFO, so a push can never find the FIFO full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) fifo[wr_ptr] <= push_pkt;
  end

endmodule
